button_conditioner: RTL

- Input-conditioning stage directly upstream of the 4-bit uP core; drives the core's 4-bit `pushbuttons` input.
- Synchronises raw asynchronous board buttons into the `clock` domain, debounces each bit independently, and presents the stable level.
- Also produces a one-cycle press pulse and a sticky press flag per bit, so firmware polling via the uP input instruction cannot miss short presses.

---
 rtl/button_pkg.sv | 16 +
 rtl/debounce_bit.sv | 120 ++++++++++++
 rtl/button_conditioner.sv | 34 +++
 3 files changed

// File: rtl/button_pkg.sv
// Shared definitions for the button conditioner: per-bit debounce FSM states
// and the default build parameters.
package button_pkg;

   localparam int DEFAULT_WIDTH           = 4;
   localparam int DEFAULT_SYNC_STAGES     = 2;
   localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

   typedef enum logic [1:0] {
      IDLE_LOW  = 2'd0,
      WAIT_HIGH = 2'd1,
      IDLE_HIGH = 2'd2,
      WAIT_LOW  = 2'd3
   } btn_state_e;

endpackage

// File: rtl/debounce_bit.sv
// Single-bit conditioner: synchroniser chain, debounce FSM with stability
// counter, and the registered level / press pulse / sticky press flag.
module debounce_bit
   import button_pkg::*;
#(
   parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   input  logic clear,
   output logic level,
   output logic pulse,
   output logic latched
);

   localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_i;
   btn_state_e             state_q, state_next;
   logic [CNT_W-1:0]       cnt_q, cnt_next;
   logic                   level_q, pulse_q, latched_q;
   logic                   high_next, pulse_next, latched_next;

   assign sync_i = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      end
   end

   always_comb begin
      state_next = state_q;
      cnt_next   = cnt_q;
      case (state_q)
         IDLE_LOW: begin
            if (sync_i) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  state_next = IDLE_HIGH;
               end else begin
                  state_next = WAIT_HIGH;
                  cnt_next   = CNT_ONE;
               end
            end
         end
         WAIT_HIGH: begin
            if (!sync_i) begin
               state_next = IDLE_LOW;
               cnt_next   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_next = IDLE_HIGH;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_q + CNT_ONE;
            end
         end
         IDLE_HIGH: begin
            if (!sync_i) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  state_next = IDLE_LOW;
               end else begin
                  state_next = WAIT_LOW;
                  cnt_next   = CNT_ONE;
               end
            end
         end
         WAIT_LOW: begin
            if (sync_i) begin
               state_next = IDLE_HIGH;
               cnt_next   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_next = IDLE_LOW;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_next = IDLE_LOW;
            cnt_next   = '0;
         end
      endcase
   end

   // A clear arriving while the pulse is set or still showing loses to the set,
   // so firmware can never wipe a press it has not yet had a chance to see.
   always_comb begin
      high_next    = (state_next == IDLE_HIGH) || (state_next == WAIT_LOW);
      pulse_next   = high_next & ~level_q;
      latched_next = pulse_next | pulse_q | (latched_q & ~clear);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE_LOW;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         pulse_q   <= 1'b0;
         latched_q <= 1'b0;
      end else begin
         state_q   <= state_next;
         cnt_q     <= cnt_next;
         level_q   <= high_next;
         pulse_q   <= pulse_next;
         latched_q <= latched_next;
      end
   end

   assign level   = level_q;
   assign pulse   = pulse_q;
   assign latched = latched_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions raw board buttons for the uP pushbuttons input: one independent
// synchronise/debounce/press-capture slice per button bit.
module button_conditioner
   import button_pkg::*;
#(
   parameter int WIDTH           = DEFAULT_WIDTH,
   parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] buttons_raw,
   input  logic [WIDTH-1:0] clear,
   output logic [WIDTH-1:0] pushbuttons,
   output logic [WIDTH-1:0] press_pulse,
   output logic [WIDTH-1:0] press_latched
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      debounce_bit #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_bit (
         .clock   (clock),
         .reset   (reset),
         .raw     (buttons_raw[i]),
         .clear   (clear[i]),
         .level   (pushbuttons[i]),
         .pulse   (press_pulse[i]),
         .latched (press_latched[i])
      );
   end

endmodule
